// File: rtl/z2_cycle_ctrl_pkg.sv
// Shared encodings for the Zorro II slave cycle controller: FSM states,
// per-channel termination modes and the timeout counter sizing helper.
package z2_cycle_ctrl_pkg;

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'd0,
    Z2_START = 2'd1,
    Z2_DATA  = 2'd2,
    Z2_END   = 2'd3
  } z2_state_e;

  localparam logic [1:0] CH_MODE_ACK = 2'b00;
  localparam logic [1:0] CH_MODE_WS  = 2'b01;
  localparam logic [1:0] CH_MODE_IMM = 2'b10;

  // Timeout counter is kept between 8 and 16 bits regardless of the requested count.
  function automatic int unsigned timeoutWidth(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/z2_cycle_ctrl_sync.sv
// Multi-flop synchroniser for one asynchronous bus strobe; resets to the
// inactive (high) level so no spurious strobe is seen after reset.
module z2_cycle_ctrl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) chain_q <= '1;
    else       chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave cycle controller: strobe synchronisation, channel arbitration
// and DTACK/OVR generation. Optional bus-error timeout enabled by Z2_TIMEOUT_EN.
module z2_cycle_ctrl
  import z2_cycle_ctrl_pkg::*;
#(
  parameter int                NUM_CH         = 4,
  parameter int                SYNC_STAGES    = 2,
  parameter int                WS_WIDTH       = 3,
  parameter logic [NUM_CH-1:0] OVR_MASK       = '0,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic                         MEMCLK,
  input  logic                         RESET,
  input  logic                         AS_n,
  input  logic                         UDS_n,
  input  logic                         LDS_n,
  input  logic                         RW,
  input  logic [NUM_CH-1:0]            ch_sel,
  input  logic [NUM_CH-1:0]            ch_ack,
  input  logic [2*NUM_CH-1:0]          ch_mode,
  input  logic [WS_WIDTH*NUM_CH-1:0]   ch_ws,
  output logic                         as_sync,
  output logic                         uds_sync,
  output logic                         lds_sync,
  output logic                         rw_sync,
  output logic [1:0]                   z2_state,
  output logic [NUM_CH-1:0]            cycle_ch,
  output logic                         cycle_start,
  output logic                         cycle_end,
  output logic                         dtack_req,
  output logic                         ovr_req,
  output logic                         berr_req
);

  z2_cycle_ctrl_sync #(.STAGES(SYNC_STAGES)) u_syncAs  (.clk_i(MEMCLK), .rst_i(RESET), .d_i(AS_n),  .q_o(as_sync));
  z2_cycle_ctrl_sync #(.STAGES(SYNC_STAGES)) u_syncUds (.clk_i(MEMCLK), .rst_i(RESET), .d_i(UDS_n), .q_o(uds_sync));
  z2_cycle_ctrl_sync #(.STAGES(SYNC_STAGES)) u_syncLds (.clk_i(MEMCLK), .rst_i(RESET), .d_i(LDS_n), .q_o(lds_sync));
  z2_cycle_ctrl_sync #(.STAGES(SYNC_STAGES)) u_syncRw  (.clk_i(MEMCLK), .rst_i(RESET), .d_i(RW),    .q_o(rw_sync));

  z2_state_e             state_q, state_d;
  logic [NUM_CH-1:0]     owner_q, owner_d, selLow;
  logic [WS_WIDTH-1:0]   wsCnt_q, wsCnt_d, ownerWs;
  logic [1:0]            ownerMode;
  logic                  ownerAck;
  logic                  dtack_q, dtack_d, start_q, start_d, end_q, end_d;

`ifdef Z2_TIMEOUT_EN
  localparam int unsigned     TO_W    = timeoutWidth(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            timedOut_q, timedOut_d, berr_q, berr_d;
`endif

  // Lowest-index hit wins; owner attributes are muxed from the one-hot owner.
  always_comb begin
    selLow    = '0;
    ownerMode = '0;
    ownerWs   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_sel[i]) begin
        selLow    = '0;
        selLow[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (owner_q[i]) begin
        ownerMode = ownerMode | ch_mode[2*i +: 2];
        ownerWs   = ownerWs | ch_ws[WS_WIDTH*i +: WS_WIDTH];
      end
    end
  end

  assign ownerAck = |(ch_ack & owner_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wsCnt_d = wsCnt_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    dtack_d = 1'b0;
`ifdef Z2_TIMEOUT_EN
    toCnt_d    = '0;
    timedOut_d = timedOut_q;
    berr_d     = 1'b0;
`endif
    if ((state_q == Z2_START || state_q == Z2_DATA) && as_sync) begin
      state_d = Z2_IDLE;
      owner_d = '0;
      end_d   = 1'b1;
    end else begin
      case (state_q)
        Z2_IDLE: begin
          if (!as_sync && |ch_sel) begin
            state_d = Z2_START;
            owner_d = selLow;
            start_d = 1'b1;
`ifdef Z2_TIMEOUT_EN
            timedOut_d = 1'b0;
`endif
          end
        end
        Z2_START: begin
          if (!uds_sync || !lds_sync) begin
            state_d = Z2_DATA;
            wsCnt_d = ownerWs;
          end
        end
        Z2_DATA: begin
          case (ownerMode)
            CH_MODE_ACK: if (ownerAck) state_d = Z2_END;
            CH_MODE_WS: begin
              if (wsCnt_q == '0) state_d = Z2_END;
              else               wsCnt_d = wsCnt_q - WS_WIDTH'(1);
            end
            default: state_d = Z2_END;
          endcase
`ifdef Z2_TIMEOUT_EN
          toCnt_d = toCnt_q + TO_W'(1);
          if (state_d == Z2_DATA && toCnt_q == TO_LAST) begin
            state_d    = Z2_END;
            timedOut_d = 1'b1;
          end
`endif
        end
        default: begin
          // END: acknowledge is registered, so it appears one cycle after entry.
          if (as_sync) begin
            state_d = Z2_IDLE;
            owner_d = '0;
            end_d   = 1'b1;
          end else begin
`ifdef Z2_TIMEOUT_EN
            dtack_d = !timedOut_q;
            berr_d  = timedOut_q;
`else
            dtack_d = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= Z2_IDLE;
      owner_q <= '0;
      wsCnt_q <= '0;
      dtack_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wsCnt_q <= wsCnt_d;
      dtack_q <= dtack_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

`ifdef Z2_TIMEOUT_EN
  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET) begin
      toCnt_q    <= '0;
      timedOut_q <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      toCnt_q    <= toCnt_d;
      timedOut_q <= timedOut_d;
      berr_q     <= berr_d;
    end
  end

  assign berr_req = berr_q;
`else
  assign berr_req = 1'b0;
`endif

  assign z2_state    = state_q;
  assign cycle_ch    = owner_q;
  assign cycle_start = start_q;
  assign cycle_end   = end_q;
  assign dtack_req   = dtack_q;
  // OVR follows AS combinationally so it releases together with the strobe.
  assign ovr_req     = (|(owner_q & OVR_MASK)) && !as_sync;

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// Self-checking bench for z2_cycle_ctrl: transaction-level model compared every
// cycle plus directed literal checks; timeout checks only with Z2_TIMEOUT_EN.
module tb_z2_cycle_ctrl;

  localparam int         NUM_CH = 4;
  localparam int         SYNC   = 2;
  localparam int         WSW    = 3;
  localparam int         TO     = 16;
  localparam logic [3:0] OVR    = 4'b0001;

  logic        MEMCLK = 1'b0;
  logic        RESET  = 1'b1;
  logic        AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1;
  logic [3:0]  ch_sel = '0, ch_ack = '0;
  logic [7:0]  ch_mode = 8'b00_01_10_10;
  logic [11:0] ch_ws = 12'b000_011_000_000;

  logic       as_sync, uds_sync, lds_sync, rw_sync;
  logic [1:0] z2_state;
  logic [3:0] cycle_ch;
  logic       cycle_start, cycle_end, dtack_req, ovr_req, berr_req;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 0;

  z2_cycle_ctrl #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .WS_WIDTH(WSW),
    .OVR_MASK(OVR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .MEMCLK(MEMCLK), .RESET(RESET), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
    .ch_sel(ch_sel), .ch_ack(ch_ack), .ch_mode(ch_mode), .ch_ws(ch_ws),
    .as_sync(as_sync), .uds_sync(uds_sync), .lds_sync(lds_sync), .rw_sync(rw_sync),
    .z2_state(z2_state), .cycle_ch(cycle_ch), .cycle_start(cycle_start), .cycle_end(cycle_end),
    .dtack_req(dtack_req), .ovr_req(ovr_req), .berr_req(berr_req)
  );

  always #5 MEMCLK = ~MEMCLK;

  // Transaction-level model: strobes are seen SYNC edges late; a cycle owns a
  // precomputed number of DATA cycles (or waits for the owner's ack).
  logic [SYNC-1:0] mAsLine = '1, mUdsLine = '1, mLdsLine = '1, mRwLine = '1;
  int         mPhase = 0, mIdx = 0, mLeft = 0, mDataCnt = 0;
  logic [3:0] mOwner = '0;
  logic       mTimed = 1'b0, mDtack = 1'b0, mBerr = 1'b0, mStart = 1'b0, mEnd = 1'b0;

  always @(posedge MEMCLK or posedge RESET) begin : model
    logic sAs, sDs, done;
    logic [1:0] md;
    if (RESET) begin
      mAsLine = '1; mUdsLine = '1; mLdsLine = '1; mRwLine = '1;
      mPhase = 0; mOwner = '0; mLeft = 0; mDataCnt = 0;
      mTimed = 0; mDtack = 0; mBerr = 0; mStart = 0; mEnd = 0;
    end else begin
      sAs = mAsLine[SYNC-1];
      sDs = mUdsLine[SYNC-1] & mLdsLine[SYNC-1];
      mStart = 0; mEnd = 0; mDtack = 0; mBerr = 0;
      if ((mPhase == 1 || mPhase == 2 || mPhase == 3) && sAs) begin
        mPhase = 0; mOwner = '0; mEnd = 1;
      end else if (mPhase == 0) begin
        if (!sAs && ch_sel != 0) begin
          mIdx = 0;
          while (!ch_sel[mIdx]) mIdx++;
          mOwner = 4'(1 << mIdx);
          mPhase = 1; mStart = 1; mTimed = 0;
        end
      end else if (mPhase == 1) begin
        if (!sDs) begin
          mPhase = 2; mDataCnt = 0;
          md = ch_mode[2*mIdx +: 2];
          if (md == 2'b01)      mLeft = int'(ch_ws[WSW*mIdx +: WSW]) + 1;
          else if (md == 2'b00) mLeft = -1;
          else                  mLeft = 1;
        end
      end else if (mPhase == 2) begin
        mDataCnt++;
        if (mLeft > 0) mLeft--;
        done = (mLeft == 0) || (mLeft < 0 && (ch_ack & mOwner) != 0);
`ifdef Z2_TIMEOUT_EN
        if (!done && mDataCnt == TO) begin done = 1; mTimed = 1; end
`endif
        if (done) mPhase = 3;
      end else begin
        mDtack = !mTimed;
        mBerr  = mTimed;
      end
      mAsLine  = {mAsLine[SYNC-2:0], AS_n};
      mUdsLine = {mUdsLine[SYNC-2:0], UDS_n};
      mLdsLine = {mLdsLine[SYNC-2:0], LDS_n};
      mRwLine  = {mRwLine[SYNC-2:0], RW};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge MEMCLK) begin
    logic [14:0] gotV, expV;
    logic expOvr;
    if (checkEn) begin
      expOvr = ((mOwner & OVR) != 0) && !mAsLine[SYNC-1];
      gotV = {z2_state, cycle_ch, cycle_start, cycle_end, dtack_req, ovr_req, berr_req,
              as_sync, uds_sync, lds_sync, rw_sync};
      expV = {2'(mPhase), mOwner, mStart, mEnd, mDtack, expOvr, mBerr,
              mAsLine[SYNC-1], mUdsLine[SYNC-1], mLdsLine[SYNC-1], mRwLine[SYNC-1]};
      checkOutput("cycle_cmp", 32'(gotV), 32'(expV));
    end
  end

  // Runs one cycle that is expected to terminate with dtack.
  task automatic applyStimulus(input logic [3:0] sel, input logic [3:0] selLater,
                               input logic [3:0] ackInit, input logic [3:0] ackLater,
                               input int ackAt, input logic rw,
                               output int dataCycles, output logic [3:0] ownerSeen,
                               output bit sawDtack, output bit sawOvr, output bit sawEnd);
    dataCycles = 0; ownerSeen = '0; sawDtack = 0; sawOvr = 0; sawEnd = 0;
    @(negedge MEMCLK);
    ch_sel = sel; ch_ack = ackInit; RW = rw; AS_n = 0; UDS_n = 0; LDS_n = 0;
    for (int k = 0; k < 60 && !sawDtack; k++) begin
      @(negedge MEMCLK);
      if (z2_state == 2'd1) ch_sel = selLater;
      if (z2_state == 2'd2) begin
        dataCycles++;
        if (dataCycles == ackAt) ch_ack = ackLater;
      end
      if (cycle_ch != 0) ownerSeen = cycle_ch;
      if (ovr_req) sawOvr = 1;
      if (dtack_req) sawDtack = 1;
    end
    if (!sawDtack) checkOutput("dtack_wait_expired", 32'(dtack_req), 32'd1);
    repeat (2) begin
      @(negedge MEMCLK);
      if (ovr_req) sawOvr = 1;
    end
    AS_n = 1; UDS_n = 1; LDS_n = 1; ch_sel = '0; ch_ack = '0;
    for (int k = 0; k < 10 && !sawEnd; k++) begin
      @(negedge MEMCLK);
      if (cycle_end) sawEnd = 1;
    end
    repeat (2) @(negedge MEMCLK);
  endtask

  // Starts a cycle and returns once DATA is observed (or the budget expires).
  task automatic startToData(input logic [3:0] sel, output bit reached);
    reached = 0;
    @(negedge MEMCLK);
    ch_sel = sel; AS_n = 0; UDS_n = 0; LDS_n = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge MEMCLK);
      if (z2_state == 2'd2) reached = 1;
    end
    if (!reached) checkOutput("data_wait_expired", 32'(z2_state), 32'd2);
  endtask

  int dc; logic [3:0] own; bit sd, so, se, reached, sawDt, sawCe;

  initial begin
    repeat (3) @(posedge MEMCLK);
    #1 RESET = 0;
    checkEn = 1;
    @(negedge MEMCLK);
    checkOutput("reset_outputs", 32'({z2_state, cycle_ch, cycle_start, cycle_end, dtack_req, ovr_req, berr_req}), 32'd0);
    checkOutput("reset_syncs", 32'({as_sync, uds_sync, lds_sync, rw_sync}), 32'hF);

    // ch1 immediate read
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 1'b1, dc, own, sd, so, se);
    checkOutput("imm_owner", 32'(own), 32'h2);
    checkOutput("imm_data_cycles", 32'(dc), 32'd1);
    checkOutput("imm_dtack_end", 32'({sd, se, so}), 32'b110);

    // ch2 wait states 3 then 0
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 1'b0, dc, own, sd, so, se);
    checkOutput("ws3_data_cycles", 32'(dc), 32'd4);
    checkOutput("ws3_owner", 32'(own), 32'h4);
    ch_ws = 12'b000_000_000_000;
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 1'b1, dc, own, sd, so, se);
    checkOutput("ws0_data_cycles", 32'(dc), 32'd1);

    // simultaneous hits, non-owner ack ignored, late ch_sel change ignored
    ch_mode = 8'b00_00_00_10;
    applyStimulus(4'b0110, 4'b0001, 4'b0100, 4'b0110, 3, 1'b1, dc, own, sd, so, se);
    checkOutput("arb_owner", 32'(own), 32'h2);
    checkOutput("ack_data_cycles", 32'(dc), 32'd3);

    // OVR on masked ch0, not on ch3
    ch_mode = 8'b10_00_00_10;
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1'b1, dc, own, sd, so, se);
    checkOutput("ovr_ch0", 32'({so, own}), 32'h11);
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, 1'b0, dc, own, sd, so, se);
    checkOutput("ovr_ch3", 32'({so, own}), 32'h08);

    // abort in DATA on ch3 (ack mode, no ack)
    ch_mode = 8'b00_00_00_10;
    sawDt = 0; sawCe = 0;
    startToData(4'b1000, reached);
    @(negedge MEMCLK);
    if (dtack_req) sawDt = 1;
    AS_n = 1; UDS_n = 1; LDS_n = 1; ch_sel = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge MEMCLK);
      if (dtack_req) sawDt = 1;
      if (cycle_end) sawCe = 1;
    end
    checkOutput("abort_no_dtack_end", 32'({sawDt, sawCe}), 32'b01);
    checkOutput("abort_idle", 32'(z2_state), 32'd0);

`ifdef Z2_TIMEOUT_EN
    // timeout on ch3 with no ack
    dc = 0; sd = 0; so = 0;
    startToData(4'b1000, reached);
    dc = 1;
    for (int k = 0; k < 40 && !so; k++) begin
      @(negedge MEMCLK);
      if (z2_state == 2'd2) dc++;
      if (dtack_req) sd = 1;
      if (berr_req) so = 1;
    end
    checkOutput("timeout_berr_dtack", 32'({so, sd}), 32'b10);
    checkOutput("timeout_data_cycles", 32'(dc), 32'(TO));
    AS_n = 1; UDS_n = 1; LDS_n = 1; ch_sel = '0;
    repeat (6) @(negedge MEMCLK);
`endif

    // reset mid-DATA
    startToData(4'b1000, reached);
    @(posedge MEMCLK);
    #1 RESET = 1;
    #1;
    checkOutput("midrst_outputs", 32'({z2_state, cycle_ch, cycle_start, cycle_end, dtack_req, ovr_req, berr_req}), 32'd0);
    checkOutput("midrst_syncs", 32'({as_sync, uds_sync, lds_sync, rw_sync}), 32'hF);
    AS_n = 1; UDS_n = 1; LDS_n = 1; ch_sel = '0;
    repeat (2) @(posedge MEMCLK);
    #1 RESET = 0;

    // recovery after reset: lowest of ch0/ch3 wins
    applyStimulus(4'b1001, 4'b1001, 4'b0000, 4'b0000, 0, 1'b1, dc, own, sd, so, se);
    checkOutput("recover_owner", 32'(own), 32'h1);
    checkOutput("recover_dtack_ovr", 32'({sd, so, se}), 32'b111);

    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "[TB] watchdog");
  end

endmodule
